// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry, LSB first.
// Optional signed-overflow output ovf_o is present when OVERFLOW_FLAG_EN is defined.
//
//  state  | meaning
//  IDLE   | waiting for operands, in_ready_o=1
//  RUN    | one bit pair per clock through the cell
//  DONE   | result held, out_valid_o=1 until accepted
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_sum, cell_cout;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  assign cell_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign cell_cout = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d = cell_cout;
        sum_d   = {cell_sum, sum_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = cell_cout;
`ifdef OVERFLOW_FLAG_EN
          // carry_q is the carry into the MSB on the final bit
          ovf_d   = carry_q ^ cell_cout;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8): vector table plus
// stall, mid-run reset and back-to-back throughput sequences.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] a, b, sum;
  logic       cin, cout;
`ifdef OVERFLOW_FLAG_EN
  logic       ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o      (sum),
    .cout_o     (cout),
    .busy_o     (busy)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf_o      (ovf)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one operand pair, measure latency to out_valid, check the result, drain it.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'hC7;
    b        = 8'h39;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    chk("sum", 32'(sum), 32'(v.s));
    chk("cout", 32'(cout), 32'(v.co));
`ifdef OVERFLOW_FLAG_EN
    chk("ovf", 32'(ovf), 32'(v.ov));
`endif
    @(negedge clk);
    chk("in_ready_after_drain", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Stall in DONE with out_ready low and fresh in_valid that must be ignored
    begin
      int lat;
      @(negedge clk);
      in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a = 8'hEE; b = 8'h77; cin = 1'b1;
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      chk("stall_latency", 32'(lat), 32'd8);
      for (int c = 0; c < 20; c++) begin
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_sum", 32'(sum), 32'h46);
        chk("stall_cout", 32'(cout), 32'd0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_in_ready", 32'(in_ready), 32'd1);
      chk("stall_release_out_valid", 32'(out_valid), 32'd0);
      chk("stall_release_busy", 32'(busy), 32'd0);
    end

    // Reset at RUN cycle 4 discards the add
    begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("midrst_no_pulse", 32'(out_valid), 32'd0);
      end
      run_vec('{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0});
    end

    // Back-to-back adds with in_valid held high
    begin
      logic [7:0] op_a[3];
      logic [7:0] op_b[3];
      logic [7:0] exp_s[3];
      int acc_t[3];
      int acc_n, res_n;
      op_a = '{8'h10, 8'h21, 8'hF0};
      op_b = '{8'h01, 8'h12, 8'h20};
      exp_s = '{8'h11, 8'h33, 8'h10};
      acc_n = 0;
      res_n = 0;
      out_ready = 1'b1;
      cin = 1'b0;
      @(negedge clk);
      for (int t = 0; t < 60; t++) begin
        if (out_valid) begin
          if (res_n < 3) chk("b2b_sum", 32'(sum), 32'(exp_s[res_n]));
          res_n++;
        end
        if (acc_n < 3) begin
          in_valid = 1'b1;
          a = op_a[acc_n];
          b = op_b[acc_n];
          if (in_ready) begin
            acc_t[acc_n] = t;
            acc_n++;
          end
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
      end
      chk("b2b_accepts", 32'(acc_n), 32'd3);
      chk("b2b_results", 32'(res_n), 32'd3);
      if (acc_n == 3) begin
        chk("b2b_gap0", 32'(acc_t[1] - acc_t[0]), 32'd10);
        chk("b2b_gap1", 32'(acc_t[2] - acc_t[1]), 32'd10);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
